// File: rtl/bcd_scan_decoder.sv
// Multiplexed BCD display scanner: one-hot decimal decode per digit,
// double-buffered display updates committed only at frame boundaries.
module bcd_scan_decoder #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter int LZB      = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic [9:0]          seg_out,
  output logic [DIGITS-1:0]   dig_sel,
  output logic                frame_start,
  output logic                load_ack,
  output logic                code_err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CMAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [W-1:0]  shadow;
  logic [W-1:0]  disp;
  logic          pending;

  logic          tick;
  logic          boundary;
  logic          commit;
  logic [W-1:0]  nxt_disp;
  logic [3:0]    cur;
  logic [DIGITS-1:0] blank;
  logic          zrun;
  logic [9:0]    seg_nxt;
  logic [DIGITS-1:0] dsel_nxt;

  function automatic logic has_bad(input logic [W-1:0] v);
    has_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) has_bad = 1'b1;
    end
  endfunction

  assign tick     = (cnt == CMAX);
  assign boundary = tick && (idx == IMAX);

  // A load on the boundary itself bypasses the shadow.
  always_comb begin
    commit   = 1'b0;
    nxt_disp = disp;
    if (boundary) begin
      if (load) begin
        commit   = 1'b1;
        nxt_disp = bcd_in;
      end else if (pending) begin
        commit   = 1'b1;
        nxt_disp = shadow;
      end
    end
  end

  // Blank a digit when it and everything above it is zero.
  always_comb begin
    blank = '0;
    zrun  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zrun     = zrun && (disp[4*k +: 4] == 4'd0);
      blank[k] = (LZB != 0) && (k != 0) && zrun;
    end
  end

  assign cur      = disp[{idx, 2'b00} +: 4];
  assign dsel_nxt = DIGITS'(1) << idx;

  always_comb begin
    seg_nxt = '0;
    if (!blank[idx] && (cur <= 4'd9)) seg_nxt = 10'd1 << cur;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= (idx == IMAX) ? '0 : idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      disp        <= '0;
      pending     <= 1'b0;
      seg_out     <= '0;
      dig_sel     <= '0;
      frame_start <= 1'b0;
      load_ack    <= 1'b0;
      code_err    <= 1'b0;
    end else begin
      if (load) shadow <= bcd_in;
      if (commit) begin
        disp     <= nxt_disp;
        pending  <= 1'b0;
        code_err <= has_bad(nxt_disp);
      end else if (load) begin
        pending <= 1'b1;
      end
      load_ack    <= commit;
      frame_start <= boundary;
      dig_sel     <= dsel_nxt;
      seg_out     <= seg_nxt;
    end
  end

endmodule

// File: doc/bcd_scan_decoder.md
BCD_SCAN_DECODER -- requirements
Module: bcd_scan_decoder

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of BCD digits scanned; legal range 1..8.
REQ-002 The block SHALL have parameter SCAN_DIV, default 1000, giving the clock cycles each digit is held; legal range >= 1.
REQ-003 The block SHALL have parameter LZB, default 1, which enables leading-zero blanking when 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port load, input, 1 bit: a strobe that captures bcd_in into the shadow register.
REQ-007 The block SHALL have port bcd_in, input, 4*DIGITS bits: digit k occupies bits [4k+3:4k], and digit 0 is least significant.
REQ-008 The block SHALL have port seg_out, output, 10 bits: a one-hot decimal line for the selected digit, or all-zero when blank or invalid.
REQ-009 The block SHALL have port dig_sel, output, DIGITS bits: a one-hot select for the digit currently driven.
REQ-010 The block SHALL have port frame_start, output, 1 bit: a one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.
REQ-011 The block SHALL have port load_ack, output, 1 bit: a one-cycle pulse when pending shadow data is committed to the display register.
REQ-012 The block SHALL have port code_err, output, 1 bit: high while the display register holds any digit value greater than 9.

Function
REQ-013 The block SHALL run a prescaler that counts 0..SCAN_DIV-1, wraps to 0, and asserts a tick in the cycle its count equals SCAN_DIV-1.
REQ-014 On each tick, the scan index SHALL advance by one, wrapping from DIGITS-1 to 0; that wrap tick is the frame boundary.
REQ-015 When load=1, the block SHALL write bcd_in to the shadow register and set pending=1; a load while pending=1 overwrites the shadow (last load wins).
REQ-016 At a frame boundary with pending=1, the block SHALL copy shadow to the display register and clear pending; the display SHALL never change mid-frame.
REQ-017 If load=1 coincides with a frame boundary, the block SHALL commit that cycle's bcd_in directly to the display register (bypass) and leave pending=0.
REQ-018 load_ack SHALL pulse high for exactly one cycle, in the cycle after the display register updates.
REQ-019 frame_start SHALL pulse in the cycle after each frame boundary, whether or not a commit occurred.
REQ-020 The decode SHALL be: digit value v in 0..9 drives seg_out[v]=1 and all other bits 0; values 10..15 drive seg_out=0.
REQ-021 With LZB=1, digit k>=1 SHALL be blanked (seg_out=0) when it and every more-significant digit equal 0; digit 0 is never blanked.
REQ-022 With LZB=0, the block SHALL perform no blanking, so value 0 always drives seg_out[0].
REQ-023 dig_sel and seg_out SHALL be registered and update together, one cycle after the scan index or display register changes; dig_sel has exactly one bit set outside reset.
REQ-024 code_err SHALL be re-evaluated on every display update: set if any committed digit is greater than 9, cleared otherwise.
REQ-025 With SCAN_DIV=1, the index SHALL advance every cycle and a frame boundary SHALL occur every DIGITS cycles.

Reset
REQ-026 While rst_n=0, the block SHALL clear prescaler, scan index, shadow, display register, pending, seg_out, dig_sel, frame_start, load_ack and code_err to 0, asynchronously.
REQ-027 On the first clock edge after rst_n rises, the block SHALL drive dig_sel=1 and seg_out=10'b0000000001 (digit 0, value 0).
REQ-028 Reset asserted mid-frame SHALL discard any pending shadow data; no load_ack is issued for discarded data.

Verification (DIGITS=4, SCAN_DIV=4, LZB=1 unless stated)
REQ-029 Reset release, no load -> dig_sel steps 0001,0010,0100,1000 every 4 cycles; seg_out is 0000000001 on digit 0 and 0 on digits 1-3; frame_start pulses every 16 cycles.
REQ-030 Load bcd_in=16'h1907 mid-frame -> display unchanged until next boundary; then load_ack pulses once, and digits 0..3 drive seg_out bits 7, 0, 9, 1 respectively.
REQ-031 Load 16'h0042 then 16'h0050 in the same frame -> only 16'h0050 is committed, with one load_ack; digit 0 drives bit 0, digit 1 drives bit 5, and digits 2-3 are blank.
REQ-032 Load 16'h00A3 -> after commit, code_err=1 and digit 1 drives seg_out=0; a later load of 16'h0003 clears code_err at its commit.
REQ-033 Load asserted exactly on the boundary cycle with 16'h0008 -> commit occurs in the same boundary, load_ack fires the next cycle, and pending stays 0.
REQ-034 Assert rst_n=0 while a load is pending, then release -> all outputs are 0 during reset, no load_ack follows, and the display shows value 0.
